// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the serial nibble adder.
package serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/FourBitAdder.sv
// 4-bit ripple adder with carry-in/out; purely combinational.
module FourBitAdder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule

// File: rtl/serial_nibble_adder.sv
// Serial nibble adder: one nibble of A+B+cin per cycle, result after NIBBLES cycles.
// in_ready only in IDLE; the result is held in DONE until out_ready (abort wins).
module serial_nibble_adder
  import serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLES*NIBBLE_W-1:0] a_in,
  input  logic [NIBBLES*NIBBLE_W-1:0] b_in,
  input  logic                        cin,
  input  logic                        abort,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLES*NIBBLE_W-1:0] sum_out,
  output logic                        cout,
  output logic                        overflow,
  output logic                        busy
);

  localparam int W     = NIBBLES * NIBBLE_W;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W-1:0]     res_q, res_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_cout;

  assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  FourBitAdder u_nibble_add (
    .A    (nib_a),
    .B    (nib_b),
    .Cin  (carry_q),
    .Sum  (nib_sum),
    .Cout (nib_cout)
  );

  // res_q is the working result; sum_q only updates on entry to DONE so the
  // visible result survives aborts and new operations in flight.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          res_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum;
          carry_d = nib_cout;
          if (idx_q == LAST_IDX) begin
            sum_d   = res_d;
            cout_d  = nib_cout;
            ovf_d   = (a_q[W-1] == b_q[W-1]) && (res_d[W-1] != a_q[W-1]);
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (abort || out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign sum_out   = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed bench for serial_nibble_adder with NIBBLES=4.
module tb_serial_nibble_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        cin;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum_out;
  logic        cout;
  logic        overflow;
  logic        busy;

  int n_checks;
  int n_fail;

  serial_nibble_adder #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand set, wait for DONE, check latency and result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] es, input logic ec,
                        input logic eo, input logic release_res, input logic acc_abort);
    int cnt;
    check({tag, "_in_ready"}, in_ready, 1);
    a_in = a; b_in = b; cin = c; in_valid = 1'b1; abort = acc_abort;
    step();
    in_valid = 1'b0; abort = 1'b0;
    check({tag, "_busy"}, busy, 1);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      step();
      cnt++;
    end
    check({tag, "_latency"}, cnt, 4);
    check({tag, "_sum"}, sum_out, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, overflow, eo);
    if (release_res) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_rel_ready"}, in_ready, 1);
      check({tag, "_rel_valid"}, out_valid, 0);
    end
  endtask

  initial begin
    int seen;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    abort = 1'b0; out_ready = 1'b0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum_out, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op("v1", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("v2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("v3", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("v4", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset two cycles into RUN.
    a_in = 16'h0F0F; b_in = 16'h0101; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    check("rrun_sum", sum_out, 0);
    check("rrun_ovf", overflow, 0);
    check("rrun_busy", busy, 0);
    check("rrun_in_ready", in_ready, 1);
    check("rrun_out_valid", out_valid, 0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("rrun_no_valid", seen, 0);

    run_op("v5", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);

    // Hold result in DONE for 5 cycles with competing operands offered.
    run_op("hold", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", sum_out, 16'h2345);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hold_rel_ready", in_ready, 1);
    check("hold_rel_sum", sum_out, 16'h2345);

    // Abort in RUN cycle 2.
    a_in = 16'h0F0F; b_in = 16'h0101; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abrun_in_ready", in_ready, 1);
    check("abrun_busy", busy, 0);
    check("abrun_sum", sum_out, 16'h2345);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("abrun_no_valid", seen, 0);

    // Abort together with out_ready in DONE.
    run_op("abdone", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    abort = 1'b1; out_ready = 1'b1;
    step();
    abort = 1'b0; out_ready = 1'b0;
    check("abdone_in_ready", in_ready, 1);
    check("abdone_valid", out_valid, 0);
    check("abdone_sum", sum_out, 16'h0003);

    // Abort in IDLE must not block acceptance.
    run_op("abidle", 16'h0005, 16'h0005, 1'b0, 16'h000A, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_nibble_adder.md
SERIAL_NIBBLE_ADDER -- requirements
Module: serial_nibble_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit digits per operand (operand width W = 4*NIBBLES).
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a_in  input  W  operand A.
REQ-008 b_in  input  W  operand B.
REQ-009 cin  input  1  carry-in to nibble 0.
REQ-010 abort  input  1  synchronous cancel of the current operation.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 sum_out  output  W  A+B+cin modulo 2^W.
REQ-014 cout  output  1  carry out of the top nibble.
REQ-015 overflow  output  1  two's-complement overflow of the W-bit sum.
REQ-016 busy  output  1  high in RUN.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 in_ready SHALL equal (state==IDLE), with no combinational path from any input.
REQ-019 In IDLE with in_valid=1: SHALL latch a_in, b_in and cin, set carry register to cin and nibble index to 0, and go to RUN.
REQ-020 Each RUN cycle SHALL add nibble[idx] of A and B plus the carry register, write the 4-bit sum into result nibble[idx], store the nibble carry-out in the carry register, and increment idx.
REQ-021 When idx==NIBBLES-1 in RUN: SHALL also load cout from the nibble carry-out, load overflow = (A[W-1]==B[W-1]) && (sum[W-1]!=A[W-1]), and go to DONE.
REQ-022 Latency SHALL be exactly NIBBLES cycles from the accepting edge to the first cycle with out_valid=1.
REQ-023 out_valid SHALL equal (state==DONE).
REQ-024 In DONE: sum_out, cout and overflow SHALL hold stable until out_ready=1, after which the FSM returns to IDLE on the next edge.
REQ-025 There is no bypass from DONE to RUN: in_valid SHALL be ignored outside IDLE.
REQ-026 abort=1 in RUN or DONE SHALL force IDLE on the next edge and suppress out_valid; abort SHALL take priority over out_ready.
REQ-027 abort SHALL have no effect in IDLE, and in_valid SHALL still be accepted in IDLE when abort=1.
REQ-028 sum_out, cout and overflow SHALL retain the last completed result while in IDLE or RUN and change only at the transition into DONE.
REQ-029 The idx width SHALL be clog2(NIBBLES), minimum 1 bit; idx SHALL NOT wrap beyond NIBBLES-1.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, idx 0, carry 0, sum_out 0, cout 0, overflow 0, out_valid 0 and busy 0; in_ready SHALL be 1.
REQ-031 Reset asserted during RUN or DONE SHALL discard the operation with no out_valid pulse after release.

Structure
REQ-032 Package serial_adder_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the constant NIBBLE_W=4.
REQ-033 The nibble datapath SHALL be one instance of the existing FourBitAdder (ports A, B, Cin, Sum, Cout), fed from the latched operands, and the design SHALL contain no other adder.

Verification (NIBBLES=4)
REQ-034 A=0x0001, B=0x0001, cin=0 -> sum_out=0x0002, cout=0, overflow=0, out_valid first high exactly 4 cycles after accept.
REQ-035 A=0xFFFF, B=0x0001, cin=0 -> sum_out=0x0000, cout=1, overflow=0 (carry ripples through all 4 nibbles); A=0x0000, B=0x0000, cin=1 -> 0x0001.
REQ-036 A=0x7FFF, B=0x0001 -> sum_out=0x8000, cout=0, overflow=1; A=0x8000, B=0x8000 -> 0x0000, cout=1, overflow=1.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; then out_ready=1 -> IDLE next edge, in_ready=1.
REQ-038 rst_n low 2 cycles into RUN -> all outputs 0 immediately, in_ready=1, and no out_valid after release.
REQ-039 abort in RUN cycle 2, and separately abort together with out_ready in DONE -> IDLE next edge, no result handshake, previous sum_out retained.
